// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared constants and helpers for the synchronous FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    // Ceiling log2; used at elaboration to size pointers and addresses.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_mem
//  Description : FIFO storage array, synchronous write, asynchronous read.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem
    import fifo_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Entries are cleared on reset so stale data can never reappear.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_param
//  Description : Parameterised single-clock FIFO, standard or FWFT read mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int DEPTH    = 16,
    parameter  int AF_LEVEL = 14,
    parameter  int AE_LEVEL = 2,
    parameter  int FWFT     = 0,
    localparam int ADDR     = clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             wr_enb,
    input  logic             rd_enb,
    output logic [WIDTH-1:0] data_out,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ADDR-1:0]  count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [ADDR-1:0] c_ONE      = ADDR'(1);
    localparam logic [ADDR-1:0] c_AF_LEVEL = ADDR'(AF_LEVEL);
    localparam logic [ADDR-1:0] c_AE_LEVEL = ADDR'(AE_LEVEL);

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two and at least 4");
    end
    if (AE_LEVEL >= AF_LEVEL) begin : g_bad_levels
        $error("sync_fifo_param: AE_LEVEL must be below AF_LEVEL");
    end

    logic [ADDR-1:0]  r_wr_ptr;
    logic [ADDR-1:0]  r_rd_ptr;
    logic [ADDR-1:0]  r_count;
    logic             r_overflow;
    logic             r_underflow;
    logic             w_full;
    logic             w_empty;
    logic             w_wr_accept;
    logic             w_rd_accept;
    logic [WIDTH-1:0] w_rd_data;

    // Flags come from registered pointers only; enables never reach them.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR-1] != r_rd_ptr[ADDR-1]) &&
                     (r_wr_ptr[ADDR-2:0] == r_rd_ptr[ADDR-2:0]);

    assign w_wr_accept = wr_enb && !w_full;
    assign w_rd_accept = rd_enb && !w_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + c_ONE;
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + c_ONE;
            end
            case ({w_wr_accept, w_rd_accept})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // A simultaneous read/write at full or empty is a defined boundary case,
    // not an error, so only an unpaired request raises the sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_enb && w_full && !rd_enb) begin
                r_overflow <= 1'b1;
            end
            if (rd_enb && w_empty && !wr_enb) begin
                r_underflow <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_wr_accept),
        .i_wr_addr (r_wr_ptr[ADDR-2:0]),
        .i_wr_data (data_in),
        .i_rd_addr (r_rd_ptr[ADDR-2:0]),
        .o_rd_data (w_rd_data)
    );

    if (FWFT == MODE_FWFT) begin : g_fwft
        assign data_out = w_rd_data;
        assign rd_valid = !w_empty;
    end else begin : g_std
        logic [WIDTH-1:0] r_data_out;
        logic             r_rd_valid;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_data_out <= '0;
                r_rd_valid <= 1'b0;
            end else begin
                r_rd_valid <= w_rd_accept;
                if (w_rd_accept) begin
                    r_data_out <= w_rd_data;
                end
            end
        end

        assign data_out = r_data_out;
        assign rd_valid = r_rd_valid;
    end

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_AF_LEVEL);
    assign almost_empty = (r_count <= c_AE_LEVEL);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo_param
//  Description : Directed self-checking bench, standard and FWFT instances.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] d0, d1;
    logic       wr0, rd0, wr1, rd1;

    logic [7:0] dout0, dout1;
    logic       vld0, full0, empty0, af0, ae0, ovf0, udf0;
    logic       vld1, full1, empty1, af1, ae1, ovf1, udf1;
    logic [4:0] cnt0, cnt1;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_std (
        .clk(clk), .reset(reset), .data_in(d0), .wr_enb(wr0), .rd_enb(rd0),
        .data_out(dout0), .rd_valid(vld0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(cnt0),
        .overflow(ovf0), .underflow(udf0)
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_fwft (
        .clk(clk), .reset(reset), .data_in(d1), .wr_enb(wr1), .rd_enb(rd1),
        .data_out(dout1), .rd_valid(vld1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(cnt1),
        .overflow(ovf1), .underflow(udf1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        d0 = '0; wr0 = 1'b0; rd0 = 1'b0;
        d1 = '0; wr1 = 1'b0; rd1 = 1'b0;
        step();
        step();
        reset = 1'b0;

        check("rst_empty", empty0, 1);
        check("rst_aempty", ae0, 1);
        check("rst_full", full0, 0);
        check("rst_afull", af0, 0);
        check("rst_count", cnt0, 0);
        check("rst_valid", vld0, 0);
        check("rst_dout", dout0, 0);
        check("rst_ovf", ovf0, 0);
        check("rst_udf", udf0, 0);
        check("rst_fwft_valid", vld1, 0);

        // Fill with 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            d0 = 8'(i); wr0 = 1'b1;
            step();
            check("fill_count", cnt0, i);
            check("fill_afull", af0, (i >= 14) ? 1 : 0);
            check("fill_aempty", ae0, (i <= 2) ? 1 : 0);
        end
        check("fill_full", full0, 1);
        d0 = 8'h11;
        step();
        wr0 = 1'b0;
        check("ovf_set", ovf0, 1);
        check("ovf_count", cnt0, 16);
        check("ovf_full", full0, 1);

        // Drain, data one cycle after each read
        rd0 = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            check("drain_data", dout0, k);
            check("drain_valid", vld0, 1);
        end
        rd0 = 1'b0;
        step();
        check("drain_valid_low", vld0, 0);
        check("drain_hold", dout0, 8'h10);
        check("drain_empty", empty0, 1);
        rd0 = 1'b1;
        step();
        rd0 = 1'b0;
        check("udf_set", udf0, 1);
        check("udf_valid", vld0, 0);
        check("udf_count", cnt0, 0);

        // Simultaneous read/write when full
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_clears_flags", {30'd0, ovf0, udf0}, 0);
        wr0 = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            d0 = 8'(i);
            step();
        end
        d0 = 8'hEE; rd0 = 1'b1;
        step();
        wr0 = 1'b0;
        check("rw_full_count", cnt0, 15);
        check("rw_full_ovf", ovf0, 0);
        check("rw_full_data", dout0, 8'h01);
        for (int k = 2; k <= 16; k++) begin
            step();
            check("rw_full_drain", dout0, k);
        end
        rd0 = 1'b0;
        step();
        check("rw_full_empty", empty0, 1);

        // Simultaneous read/write when empty
        d0 = 8'h77; wr0 = 1'b1; rd0 = 1'b1;
        step();
        wr0 = 1'b0; rd0 = 1'b0;
        check("rw_empty_count", cnt0, 1);
        check("rw_empty_valid", vld0, 0);
        check("rw_empty_udf", udf0, 0);
        rd0 = 1'b1;
        step();
        rd0 = 1'b0;
        check("rw_empty_data", dout0, 8'h77);
        check("rw_empty_drained", empty0, 1);

        // Wrap: occupancy 3, 40 cycles of simultaneous traffic
        wr0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d0 = 8'(8'h80 + i);
            step();
        end
        rd0 = 1'b1;
        for (int j = 0; j < 40; j++) begin
            d0 = 8'(8'h83 + j);
            step();
            check("wrap_data", dout0, 8'h80 + j);
            check("wrap_count", cnt0, 3);
        end
        rd0 = 1'b0;
        check("wrap_ovf", ovf0, 0);
        check("wrap_udf", udf0, 0);

        // Reset mid-operation at count 9 with a write pending
        for (int i = 0; i < 6; i++) begin
            d0 = 8'(8'hC0 + i);
            step();
        end
        check("pre_rst_count", cnt0, 9);
        d0 = 8'h55; reset = 1'b1;
        step();
        check("midrst_count", cnt0, 0);
        check("midrst_empty", empty0, 1);
        check("midrst_dout", dout0, 0);
        check("midrst_flags", {30'd0, ovf0, udf0}, 0);
        reset = 1'b0; wr0 = 1'b0;
        step();
        check("midrst_discard", empty0, 1);

        // FWFT first word and advance
        check("fwft_idle_valid", vld1, 0);
        d1 = 8'hA5; wr1 = 1'b1;
        step();
        wr1 = 1'b0;
        check("fwft_first_data", dout1, 8'hA5);
        check("fwft_first_valid", vld1, 1);
        rd1 = 1'b1;
        step();
        rd1 = 1'b0;
        check("fwft_read_empty", empty1, 1);
        check("fwft_read_valid", vld1, 0);
        wr1 = 1'b1; d1 = 8'hB1;
        step();
        d1 = 8'hB2;
        step();
        wr1 = 1'b0;
        check("fwft_head", dout1, 8'hB1);
        rd1 = 1'b1;
        step();
        rd1 = 1'b0;
        check("fwft_next", dout1, 8'hB2);
        check("fwft_next_count", cnt1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
